// File: rtl/debounce_pkg.sv
// debounce_pkg: edge-mode encodings and width helper shared by the debouncer files
package debounce_pkg;
  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronised, stability-filtered input with edge qualification
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sig,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_thr,
  output logic             o_level,
  output logic             o_pulse,
  output logic             o_edge,
  output logic             o_dir
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_commit;
  logic [CNT_W:0]         w_inc;
  logic [CNT_W:0]         w_thr;

  // counter compare is one bit wider than the counter so cnt+1 never wraps
  always_comb begin
    w_s      = r_sync[SYNC_STAGES-1];
    w_diff   = w_s != r_level;
    w_thr    = (i_thr == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, i_thr};
    w_inc    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_commit = i_en && w_diff && (w_inc >= w_thr);
    o_edge   = w_commit && (i_mode != MODE_LEVEL) &&
               ((i_mode == MODE_BOTH) || (i_mode == (w_s ? MODE_RISE : MODE_FALL)));
    o_dir    = w_s;
    o_level  = r_level;
    o_pulse  = r_pulse;
  end

  // synchroniser, stability counter, committed level and registered edge pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_pulse <= o_edge;
      if (w_commit) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= (i_en && w_diff) ? w_inc[CNT_W-1:0] : '0;
      end
    end
  end
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: bank of debounced channels with a prioritised pending-event port
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  CNT_W       = 11,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = clog2_min1(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [CHANNELS-1:0]   chan_en,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CNT_W-1:0]      threshold,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [CH_W-1:0]       evt_channel,
  output logic                  evt_rise,
  output logic [CHANNELS-1:0]   ovf_flags,
  input  logic                  ovf_clear
);
  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_dir;
  logic [CHANNELS-1:0] w_xfer;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_pdir;
  logic [CHANNELS-1:0] r_ovf;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_sig  (signal_in[g]),
      .i_en   (chan_en[g]),
      .i_mode (mode[2*g +: 2]),
      .i_thr  (threshold),
      .o_level(level_out[g]),
      .o_pulse(pulse_out[g]),
      .o_edge (w_edge[g]),
      .o_dir  (w_dir[g])
    );
  end

  // lowest-index pending channel is presented; one-hot transfer mask on handshake
  always_comb begin
    evt_channel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (r_pend[i]) evt_channel = CH_W'(i);
    evt_valid = |r_pend;
    evt_rise  = r_pdir[evt_channel];
    w_xfer    = (evt_valid && evt_ready) ? (CHANNELS'(1) << evt_channel) : '0;
    ovf_flags = r_ovf;
  end

  // a new edge always re-arms pending; overflow only when an unsent event is overwritten
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_pdir <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= w_edge | (r_pend & ~w_xfer);
      r_pdir <= (w_edge & w_dir) | (~w_edge & r_pdir);
      r_ovf  <= (w_edge & r_pend & ~w_xfer) | (r_ovf & ~{CHANNELS{ovf_clear}});
    end
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed stimulus with a queued event scoreboard and negedge monitor
module tb_multi_debouncer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  signal_in = 4'h0;
  logic [3:0]  chan_en = 4'hF;
  logic [7:0]  mode = 8'h00;
  logic [10:0] threshold = 11'd5;
  logic        evt_ready = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [3:0]  level_out;
  logic [3:0]  pulse_out;
  logic        evt_valid;
  logic [1:0]  evt_channel;
  logic        evt_rise;
  logic [3:0]  ovf_flags;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt[4];
  logic [2:0]  exp_q[$];

  multi_debouncer #(.CHANNELS(4), .CNT_W(11), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .signal_in(signal_in), .chan_en(chan_en),
    .mode(mode), .threshold(threshold), .level_out(level_out), .pulse_out(pulse_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_channel(evt_channel),
    .evt_rise(evt_rise), .ovf_flags(ovf_flags), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic rise);
    exp_q.push_back({rise, 2'(ch)});
  endtask

  // monitor: counts pulses and pops the expected event on every handshake
  initial begin : mon
    logic [2:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (pulse_out[i]) pulse_cnt[i]++;
      if (reset_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got ch=%0d rise=%0d expected none", evt_channel, evt_rise);
        end else begin
          e = exp_q.pop_front();
          check("event", {29'd0, evt_rise, evt_channel}, {29'd0, e});
        end
      end
    end
  end

  initial begin : stim
    int base[4];
    mode = 8'b00_00_00_01;
    tick(3);
    check("rst_level", level_out, 4'h0);
    check("rst_pulse", pulse_out, 4'h0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_ovf", ovf_flags, 4'h0);
    reset_n = 1'b1;
    // clean step on ch0, threshold 5
    push(0, 1'b1);
    signal_in[0] = 1'b1;
    tick(6);
    check("step_early", level_out[0], 1'b0);
    tick(1);
    check("step_level", level_out[0], 1'b1);
    check("step_pulse", pulse_out[0], 1'b1);
    check("step_valid", evt_valid, 1'b1);
    check("step_chan", evt_channel, 2'd0);
    check("step_rise", evt_rise, 1'b1);
    evt_ready = 1'b1;
    tick(1);
    check("step_pulse_end", pulse_out[0], 1'b0);
    check("step_cleared", evt_valid, 1'b0);
    check("step_pulse_cnt", pulse_cnt[0], 1);
    // glitch of 4 cycles on ch1 is rejected
    mode = 8'b00_00_01_01;
    base[1] = pulse_cnt[1];
    signal_in[1] = 1'b1;
    tick(4);
    signal_in[1] = 1'b0;
    tick(10);
    check("glitch_level", level_out[1], 1'b0);
    check("glitch_pulse", pulse_cnt[1] - base[1], 0);
    check("glitch_valid", evt_valid, 1'b0);
    // threshold 0 behaves as 1
    threshold = 11'd0;
    push(1, 1'b1);
    signal_in[1] = 1'b1;
    tick(1);
    signal_in[1] = 1'b0;
    tick(1);
    check("thr0_early", level_out[1], 1'b0);
    tick(1);
    check("thr0_level", level_out[1], 1'b1);
    tick(3);
    check("thr0_back", level_out[1], 1'b0);
    check("thr0_pulse", pulse_cnt[1] - base[1], 1);
    // modes 00/01/10/11 on ch0..ch3
    signal_in = 4'h0;
    mode = 8'h00;
    threshold = 11'd3;
    tick(10);
    for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
    mode = 8'b11_10_01_00;
    push(1, 1'b1);
    push(3, 1'b1);
    signal_in = 4'hF;
    tick(10);
    check("mode_level_hi", level_out, 4'hF);
    push(2, 1'b0);
    push(3, 1'b0);
    signal_in = 4'h0;
    tick(10);
    check("mode_level_lo", level_out, 4'h0);
    check("mode00_pulses", pulse_cnt[0] - base[0], 0);
    check("mode01_pulses", pulse_cnt[1] - base[1], 1);
    check("mode10_pulses", pulse_cnt[2] - base[2], 1);
    check("mode11_pulses", pulse_cnt[3] - base[3], 2);
    // priority and overflow with ready low
    evt_ready = 1'b0;
    mode = 8'hFF;
    signal_in = 4'b0110;
    tick(5);
    check("prio_valid", evt_valid, 1'b1);
    check("prio_chan", evt_channel, 2'd1);
    check("prio_rise", evt_rise, 1'b1);
    push(1, 1'b0);
    push(2, 1'b1);
    signal_in[1] = 1'b0;
    tick(5);
    check("ovf_flags", ovf_flags, 4'b0010);
    check("ovf_chan", evt_channel, 2'd1);
    check("ovf_rise", evt_rise, 1'b0);
    evt_ready = 1'b1;
    tick(2);
    check("drain_valid", evt_valid, 1'b0);
    check("ovf_sticky", ovf_flags, 4'b0010);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    check("ovf_cleared", ovf_flags, 4'h0);
    // transfer and new edge on the same channel in one cycle
    threshold = 11'd1;
    push(0, 1'b1);
    push(0, 1'b0);
    signal_in[0] = 1'b1;
    tick(1);
    signal_in[0] = 1'b0;
    tick(2);
    check("same_first_rise", evt_rise, 1'b1);
    tick(1);
    check("same_valid", evt_valid, 1'b1);
    check("same_chan", evt_channel, 2'd0);
    check("same_rise", evt_rise, 1'b0);
    check("same_ovf", ovf_flags, 4'h0);
    tick(1);
    check("same_drained", evt_valid, 1'b0);
    // reset in the middle of a count
    threshold = 11'd5;
    signal_in[0] = 1'b1;
    tick(5);
    reset_n = 1'b0;
    tick(1);
    check("midrst_level", level_out, 4'h0);
    check("midrst_pulse", pulse_out, 4'h0);
    check("midrst_valid", evt_valid, 1'b0);
    check("midrst_ovf", ovf_flags, 4'h0);
    reset_n = 1'b1;
    push(0, 1'b1);
    push(2, 1'b1);
    tick(6);
    check("midrst_recount", level_out, 4'h0);
    tick(1);
    check("midrst_commit", level_out, 4'b0101);
    tick(4);
    // disabled channel freezes level and raises no events
    base[0] = pulse_cnt[0];
    chan_en = 4'b1110;
    signal_in[0] = 1'b0;
    tick(10);
    signal_in[0] = 1'b1;
    tick(3);
    signal_in[0] = 1'b0;
    tick(10);
    check("dis_level", level_out[0], 1'b1);
    check("dis_pulse", pulse_cnt[0] - base[0], 0);
    check("dis_valid", evt_valid, 1'b0);
    tick(3);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
